// File: rtl/banked_ram.sv
// banked_ram: parametrised banked simple-dual-port synchronous RAM.
// NUM_BANKS = 2**BANK_SEL_SIZE banks of 2**BANK_ADDR_SIZE rows, RAM_WIDTH bits per row.
// Byte-enabled writes, one-cycle registered reads with rd_valid, muxed output.
// After every reset, a hardware sweep zeroes all rows. Requests are ignored until it completes.
// Optional build macro RAM_BYPASS_EN:
//   - defined: a same-address read/write collision returns the freshly written bytes;
//   - undefined: the read returns the pre-write contents.
module banked_ram #(
   parameter int RAM_WIDTH      = 64,
   parameter int BANK_SEL_SIZE  = 2,
   parameter int BANK_ADDR_SIZE = 10
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    write,
   input  logic [BANK_SEL_SIZE+BANK_ADDR_SIZE-1:0] wr_address,
   input  logic [RAM_WIDTH-1:0]                    data_in,
   input  logic [RAM_WIDTH/8-1:0]                  wr_be,
   input  logic                                    read,
   input  logic [BANK_SEL_SIZE+BANK_ADDR_SIZE-1:0] rd_address,
   output logic [RAM_WIDTH-1:0]                    data_out,
   output logic                                    rd_valid,
   output logic                                    init_busy
);

   localparam int ADDR_SIZE  = BANK_SEL_SIZE + BANK_ADDR_SIZE;
   localparam int NUM_BANKS  = 2 ** BANK_SEL_SIZE;
   localparam int BANK_DEPTH = 2 ** BANK_ADDR_SIZE;
   localparam int NUM_BYTES  = RAM_WIDTH / 8;

   localparam logic STATE_INIT  = 1'b0;
   localparam logic STATE_READY = 1'b1;

   logic                      state;
   logic [BANK_ADDR_SIZE-1:0] sweep_cnt;

   // Stage p0: request decode (bank/row split, READY gating, collision detect)
   logic                      wr_en_p0;
   logic                      rd_en_p0;
   logic                      bypass_p0;
   logic [BANK_SEL_SIZE-1:0]  wr_bank_p0;
   logic [BANK_SEL_SIZE-1:0]  rd_bank_p0;
   logic [BANK_ADDR_SIZE-1:0] wr_row_p0;
   logic [BANK_ADDR_SIZE-1:0] rd_row_p0;

   // Stage p1: registered per-bank read words, bank index and valid
   logic [RAM_WIDTH-1:0]      bank_q [NUM_BANKS];
   logic [BANK_SEL_SIZE-1:0]  rd_bank_p1;
   logic                      vld_p1;

   assign wr_bank_p0 = wr_address[ADDR_SIZE-1 -: BANK_SEL_SIZE];
   assign rd_bank_p0 = rd_address[ADDR_SIZE-1 -: BANK_SEL_SIZE];
   assign wr_row_p0  = wr_address[BANK_ADDR_SIZE-1:0];
   assign rd_row_p0  = rd_address[BANK_ADDR_SIZE-1:0];

   assign wr_en_p0   = write && (state == STATE_READY);
   assign rd_en_p0   = read  && (state == STATE_READY);

`ifdef RAM_BYPASS_EN
   // Same full address on both ports: the read word is merged with the enabled write bytes.
   assign bypass_p0  = wr_en_p0 && rd_en_p0 && (wr_address == rd_address);
`else
   // No forwarding: a colliding read sees the row as it was before this edge.
   assign bypass_p0  = 1'b0;
`endif

   // Sweep control: INIT zeroes one row per cycle in every bank, READY serves requests
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= STATE_INIT;
         sweep_cnt <= '0;
      end else if (state == STATE_INIT) begin
         if (sweep_cnt == {BANK_ADDR_SIZE{1'b1}}) begin
            // Last row is written on this edge; the counter stops here instead of wrapping.
            state <= STATE_READY;
         end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [RAM_WIDTH-1:0] mem [BANK_DEPTH];
      logic                 bank_wr_p0;
      logic                 bank_rd_p0;
      logic [RAM_WIDTH-1:0] rd_word_p0;
      logic [RAM_WIDTH-1:0] rd_data_p1;

      assign bank_wr_p0 = wr_en_p0 && (wr_bank_p0 == BANK_SEL_SIZE'(b));
      assign bank_rd_p0 = rd_en_p0 && (rd_bank_p0 == BANK_SEL_SIZE'(b));

      // Storage update: sweep zeroing during INIT, byte-masked writes in READY
      always_ff @(posedge clk) begin
         if (state == STATE_INIT) begin
            mem[sweep_cnt] <= '0;
         end else if (bank_wr_p0) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
               if (wr_be[i]) begin
                  mem[wr_row_p0][8*i +: 8] <= data_in[8*i +: 8];
               end
            end
         end
      end

      // Read word for this bank, with enabled write bytes forwarded on a collision
      always_comb begin
         rd_word_p0 = mem[rd_row_p0];
         if (bypass_p0) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
               if (wr_be[i]) begin
                  rd_word_p0[8*i +: 8] = data_in[8*i +: 8];
               end
            end
         end
      end

      // Stage p1 read register; it holds when this bank is not being read
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rd_data_p1 <= '0;
         end else if (bank_rd_p0) begin
            rd_data_p1 <= rd_word_p0;
         end
      end

      assign bank_q[b] = rd_data_p1;
   end

   // Stage p1 control: bank index follows each accepted read, valid pulses once per read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         rd_bank_p1 <= '0;
      end else begin
         vld_p1 <= rd_en_p0;
         if (rd_en_p0) begin
            rd_bank_p1 <= rd_bank_p0;
         end
      end
   end

   assign data_out  = bank_q[rd_bank_p1];
   assign rd_valid  = vld_p1;
   assign init_busy = (state == STATE_INIT);

endmodule

// File: tb/tb_banked_ram.sv
// tb_banked_ram: scoreboard bench for banked_ram at default parameters.
// The driver pushes the expected word for every read it issues.
// A monitor pops and compares whenever rd_valid is seen.
// Build with +define+RAM_BYPASS_EN to check the forwarding variant.
module tb_banked_ram;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write;
   logic [11:0] wr_address;
   logic [63:0] data_in;
   logic [7:0]  wr_be;
   logic        read;
   logic [11:0] rd_address;
   logic [63:0] data_out;
   logic        rd_valid;
   logic        init_busy;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q  [$];
   string       name_q [$];

`ifdef RAM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic [63:0] tp [8] = '{64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002,
                           64'h0003_0003_0003_0003, 64'h0004_0004_0004_0004,
                           64'h0005_0005_0005_0005, 64'h0006_0006_0006_0006,
                           64'h0007_0007_0007_0007, 64'h0008_0008_0008_0008};

   banked_ram dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .write      (write),
      .wr_address (wr_address),
      .data_in    (data_in),
      .wr_be      (wr_be),
      .read       (read),
      .rd_address (rd_address),
      .data_out   (data_out),
      .rd_valid   (rd_valid),
      .init_busy  (init_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, req);
      end
   endtask

   // One cycle of stimulus, driven at the falling edge; reads queue their expected word.
   task automatic drive(input logic w, input logic [11:0] wa, input logic [63:0] wd,
                        input logic [7:0] be, input logic r, input logic [11:0] ra,
                        input logic [63:0] rexp, input string nm);
      @(negedge clk);
      write      = w;
      wr_address = wa;
      data_in    = wd;
      wr_be      = be;
      read       = r;
      rd_address = ra;
      if (r) begin
         exp_q.push_back(rexp);
         name_q.push_back(nm);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic [7:0] be);
      drive(1'b1, a, d, be, 1'b0, 12'h000, 64'd0, "");
   endtask

   task automatic rd(input logic [11:0] a, input logic [63:0] e, input string nm);
      drive(1'b0, 12'h000, 64'd0, 8'h00, 1'b1, a, e, nm);
   endtask

   task automatic idle();
      drive(1'b0, 12'h000, 64'd0, 8'h00, 1'b0, 12'h000, 64'd0, "");
   endtask

   // Hold reset for n rising edges, then check the reset values while rst_n is still low.
   task automatic do_reset(input int n, input string nm);
      @(negedge clk);
      rst_n = 1'b0;
      write = 1'b0;
      read  = 1'b0;
      repeat (n) @(negedge clk);
      check({nm, "_data_out"},  data_out, 64'd0);
      check({nm, "_rd_valid"},  64'(rd_valid), 64'd0);
      check({nm, "_init_busy"}, 64'(init_busy), 64'd1);
   endtask

   // Count rising edges after release until init_busy drops; bounded.
   task automatic wait_sweep(input string nm, input int start);
      int n;
      n = start;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (init_busy === 1'b1 && n < 2000);
      check(nm, 64'(n), 64'd1024);
   endtask

   // Monitor: every rd_valid must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("spurious_rd_valid", 64'(rd_valid), 64'd0);
            end else begin
               check(name_q.pop_front(), data_out, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      write      = 1'b0;
      read       = 1'b0;
      wr_address = '0;
      rd_address = '0;
      data_in    = '0;
      wr_be      = '0;

      // Power-up reset and full sweep, with a read attempted during INIT.
      do_reset(3, "rst");
      rst_n      = 1'b1;
      read       = 1'b1;
      rd_address = 12'h000;
      @(posedge clk);
      #1;
      check("init_read_valid", 64'(rd_valid), 64'd0);
      read = 1'b0;
      wait_sweep("sweep_len", 1);

      rd(12'h000, 64'd0, "zero_000");
      rd(12'h3FF, 64'd0, "zero_3ff");
      rd(12'h400, 64'd0, "zero_400");
      rd(12'hFFF, 64'd0, "zero_fff");

      // Bank isolation on row 5.
      wr(12'h005, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      wr(12'hC05, 64'h5555_5555_5555_5555, 8'hFF);
      rd(12'h005, 64'hAAAA_AAAA_AAAA_AAAA, "bank0_row5");
      rd(12'hC05, 64'h5555_5555_5555_5555, "bank3_row5");
      rd(12'h405, 64'd0,                   "bank1_row5");

      // Byte enables.
      wr(12'h010, 64'h1122_3344_5566_7788, 8'hFF);
      wr(12'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      rd(12'h010, 64'h1122_3344_FFFF_FFFF, "byte_enable");

      // Same-address collisions, full and partial byte enables.
      wr(12'h020, 64'h1, 8'hFF);
      drive(1'b1, 12'h020, 64'h2, 8'hFF, 1'b1, 12'h020, BYP ? 64'h2 : 64'h1, "collision");
      rd(12'h020, 64'h2, "collision_after");
      wr(12'h030, 64'h1111_1111_1111_1111, 8'hFF);
      drive(1'b1, 12'h030, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 1'b1, 12'h030,
            BYP ? 64'hFFFF_FFFF_1111_1111 : 64'h1111_1111_1111_1111, "collision_be");
      rd(12'h030, 64'hFFFF_FFFF_1111_1111, "collision_be_after");
      wr(12'h030, 64'h0, 8'h00);
      rd(12'h030, 64'hFFFF_FFFF_1111_1111, "be_zero_noop");

      // Independent read and write to different banks in one cycle.
      drive(1'b1, 12'h105, 64'hDEAD_BEEF_0000_0105, 8'hFF, 1'b1, 12'hC05,
            64'h5555_5555_5555_5555, "indep_read");
      rd(12'h105, 64'hDEAD_BEEF_0000_0105, "indep_write");

      // Back-to-back burst, then hold.
      for (int i = 1; i <= 8; i++) wr(12'(i), tp[i-1], 8'hFF);
      for (int i = 1; i <= 8; i++) rd(12'(i), tp[i-1], "burst");
      idle();
      @(negedge clk);
      check("burst_drained",   64'(exp_q.size()), 64'd0);
      check("burst_end_valid", 64'(rd_valid), 64'd0);
      check("hold_data",       data_out, tp[7]);
      idle();
      idle();
      idle();
      check("hold_data_later", data_out, tp[7]);

      // Reset in READY, then a second reset 500 cycles into that sweep.
      do_reset(1, "ready_rst");
      rst_n = 1'b1;
      repeat (500) @(posedge clk);
      #1;
      check("midsweep_busy", 64'(init_busy), 64'd1);
      do_reset(1, "mid_rst");
      rst_n = 1'b1;
      wait_sweep("sweep_restart", 0);

      rd(12'h005, 64'd0, "rezero_005");
      rd(12'hC05, 64'd0, "rezero_c05");
      rd(12'h010, 64'd0, "rezero_010");
      rd(12'h105, 64'd0, "rezero_105");
      idle();
      idle();
      @(negedge clk);
      check("final_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/banked_ram.md
# banked_ram

Parametrised, banked, simple-dual-port synchronous RAM. It is the successor to the fixed 4-bank, 4096 x 64 memory. Bank count, width and per-bank depth are configurable. It adds:
- byte-enabled writes;
- a registered read-valid;
- a muxed (non-tristate) output;
- a hardware zero-initialisation sweep after reset.

It sits behind the datapath as the general-purpose storage array.

## Interface
Parameters:
- RAM_WIDTH, 64, data width in bits; must be a multiple of 8.
- BANK_SEL_SIZE, 2, bank-select bits; NUM_BANKS = 2**BANK_SEL_SIZE.
- BANK_ADDR_SIZE, 10, per-bank address bits; BANK_DEPTH = 2**BANK_ADDR_SIZE.
- ADDR_SIZE (local), BANK_SEL_SIZE+BANK_ADDR_SIZE; total depth = 2**ADDR_SIZE.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  RAM clock; all state updates on its rising edge.
  - rst_n  in  1  synchronous active-low reset.
- Write port:
  - write  in  1  write request.
  - wr_address  in  ADDR_SIZE  write address; the MSBs select the bank.
  - data_in  in  RAM_WIDTH  write data.
  - wr_be  in  RAM_WIDTH/8  byte enables; bit i enables data_in[8i+7:8i].
- Read port:
  - read  in  1  read request.
  - rd_address  in  ADDR_SIZE  read address; the MSBs select the bank.
  - data_out  out  RAM_WIDTH  read data, registered.
  - rd_valid  out  1  data_out holds the result of a read issued on the previous cycle.
- Status:
  - init_busy  out  1  zero-initialisation sweep in progress; requests are ignored.

## Operation
- Address split:
  - bank = addr[ADDR_SIZE-1 -: BANK_SEL_SIZE];
  - row = addr[BANK_ADDR_SIZE-1:0].
- Write: when write=1 and the FSM is READY, only the selected bank updates row, and only in the bytes whose wr_be bit is 1. A write with wr_be=0 is a no-op.
- Read: when read=1 and the FSM is READY, the selected bank's row is registered. The bank index is registered alongside it, and a NUM_BANKS:1 mux drives data_out. No tristate.
- When read=0, data_out holds its previous value.
- FSM states:
  - INIT:
    - on rst_n=0, state <= INIT and sweep counter <= 0;
    - each cycle in INIT writes all-zero to row[counter] of every bank in parallel;
    - on counter = BANK_DEPTH-1, state <= READY. Counter arithmetic is BANK_ADDR_SIZE bits and ends before wrap.
  - READY: normal operation. Remains here until rst_n=0.
- In INIT, read and write are ignored, and rd_valid stays 0.
- Same-address collision (read and write to the same full address in the same cycle): see Configuration.
- A read and a write to different banks or rows proceed independently in the same cycle.
- Out-of-range addresses do not exist: all 2**ADDR_SIZE addresses are valid.

## Timing
- Reset values while rst_n=0 is sampled:
  - data_out=0, rd_valid=0, init_busy=1;
  - sweep counter=0, state=INIT.
- Memory contents are not cleared by reset itself; the sweep clears them.
- Sweep duration: init_busy=1 for exactly BANK_DEPTH cycles after the first clock edge with rst_n=1. init_busy falls on the edge that completes the last row (1024 cycles at the defaults).
- Reset asserted mid-sweep restarts the sweep at row 0.
- Reset asserted in READY forces INIT, and the whole array is re-zeroed.
- Read latency is 1: a read sampled at edge N gives data_out and rd_valid=1 after edge N. rd_valid=0 after any edge where read=0 or the FSM is not READY.
- A write sampled at edge N is visible to a read sampled at edge N+1 or later.
- Back-to-back reads and writes are allowed every cycle, with no stalls and no handshake back-pressure.

## Configuration
- Macro: RAM_BYPASS_EN.
- Defined: on a same-address read/write collision, data_out returns the new data.
  - Enabled bytes come from data_in; disabled bytes come from the old memory contents.
- Undefined: on a collision, data_out returns the old (pre-write) contents; the write still commits.
- In both builds the memory state after the cycle is identical.

## Test plan
- Reset and sweep: hold rst_n=0 for 3 cycles, then release.
  - Required: init_busy=1 for exactly 1024 cycles; a read of 0x000 issued during INIT gives rd_valid=0.
  - After the sweep, reads of 0x000, 0x3FF, 0x400 and 0xFFF return 0 with rd_valid=1.
- Bank isolation: write 0xAAAA_AAAA_AAAA_AAAA to 0x005 and 0x5555_5555_5555_5555 to 0xC05, wr_be=0xFF.
  - Required: reading 0x005 gives 0xAAAA…; 0xC05 gives 0x5555…; 0x405 gives 0.
- Byte enables: write 0x1122_3344_5566_7788 to 0x010 with wr_be=0xFF, then 0xFFFF_FFFF_FFFF_FFFF with wr_be=0x0F.
  - Required: reading 0x010 gives 0x1122_3344_FFFF_FFFF.
- Collision: location 0x020=0x1 from a prior write; in one cycle write 0x2 to 0x020 (wr_be=0xFF) and read 0x020.
  - Required without the macro: data_out=0x1.
  - Required with RAM_BYPASS_EN: data_out=0x2.
  - A following read returns 0x2 in both builds.
- Throughput and hold: issue reads to 0x001..0x008 on 8 consecutive cycles, then read=0.
  - Required: rd_valid=1 for 8 consecutive cycles with matching data, then 0; data_out keeps the 0x008 value.
- Mid-sweep reset: assert rst_n=0 at sweep cycle 500 for 1 cycle.
  - Required: init_busy stays 1 for another full 1024 cycles, and location 0x005 (written before the reset) reads 0 afterwards.
